branch_hazard_controller: RTL and testbench
===========================================

Name: branch_hazard_controller

Overview:
- Sequences the ID-stage branch/jump resolution unit.
- Detects data hazards on the branch operand registers (rs/rt) against in-flight EX/MEM/WB writers.
- Stalls PC and IF/ID and injects ID/EX bubbles for exactly the required cycle count, drives forwarding selects for the ID compare operands, and gates the redirect.
- Keeps saturating performance counters for branches, taken branches and stall cycles.

Parameters:
- CNT_W, 16, width of each performance counter.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_instruction  in  32  instruction in ID; opcode [31:26], rs [25:21], rt [20:16].
- ID_valid  in  1  ID holds a real instruction (not a bubble).
- EX_regwrite  in  1  EX instruction writes a register.
- EX_memread  in  1  EX instruction is a load.
- EX_rd  in  REG_W  EX destination register.
- MEM_regwrite  in  1  MEM instruction writes a register.
- MEM_memread  in  1  MEM instruction is a load.
- MEM_rd  in  REG_W  MEM destination register.
- WB_regwrite  in  1  WB instruction writes a register.
- WB_rd  in  REG_W  WB destination register.
- branch_taken  in  1  pcsrc from the branch resolution unit.
- clr_counters  in  1  synchronous clear of the performance counters.
- pc_write  out  1  PC update enable.
- IFID_write  out  1  IF/ID register enable.
- IDEX_bubble  out  1  zero the control bits of ID/EX.
- fwd_sel_a  out  2  rs operand source: 00 regfile, 01 MEM ALU result, 10 WB data.
- fwd_sel_b  out  2  rt operand source, same encoding as fwd_sel_a.
- branch_resolve  out  1  qualifies branch_taken; the PC redirect and IF/ID flush are honoured only when this is 1.
- branch_count  out  CNT_W  resolved conditional branches.
- taken_count  out  CNT_W  resolved taken conditional branches.
- stall_count  out  CNT_W  stall cycles inserted.

Behaviour:
- Opcode decode:
  - JUMP 000010 and JAL 000110 read no registers.
  - JR 000111 reads rs only.
  - BEQ 000100, BNE 000001, BLT 000011 and BGE 000101 read rs and rt.
  - All other opcodes are non-control: no stall from this block, branch_resolve=0.
- Operand usage: a source operand is "used" only when the opcode reads it and its index is nonzero. r0 never causes a hazard or forwarding.
- Required stall cycles per used operand:
  - 2 if EX_memread and EX_rd matches.
  - 1 if EX_regwrite (not load) and EX_rd matches.
  - 1 if MEM_memread and MEM_rd matches.
  - 0 otherwise.
  - N = max over both used operands (0..2).
- FSM states: RUN, STALL; 2-bit remaining counter rem.
- RUN:
  - If ID_valid and N>0, assert stall this same cycle.
  - Load rem<=N-1.
  - Next state is STALL if N==2, else RUN (re-evaluate next cycle).
- STALL:
  - Assert stall unconditionally; hazard inputs are ignored.
  - rem<=rem-1.
  - Go to RUN when rem==1 at the edge.
- Stall cycle outputs: pc_write=0, IFID_write=0, IDEX_bubble=1, branch_resolve=0.
- Non-stall cycle outputs: pc_write=1, IFID_write=1, IDEX_bubble=0, branch_resolve = ID_valid & control opcode.
- Forwarding (combinational, every cycle, per operand):
  - 01 if MEM_regwrite & !MEM_memread & MEM_rd==reg & reg!=0.
  - Else 10 if WB_regwrite & WB_rd==reg & reg!=0.
  - Else 00.
  - MEM has priority over WB.
- Counters, updated at the clock edge:
  - branch_count +1 when branch_resolve and the opcode is BEQ/BNE/BLT/BGE.
  - taken_count +1 when that condition holds and branch_taken is also 1.
  - stall_count +1 on every stall cycle.
  - All counters saturate at 2^CNT_W-1.
  - clr_counters zeroes all three and wins over a simultaneous increment.
- Reset:
  - State RUN, rem=0, all counters 0.
  - pc_write=1, IFID_write=1, IDEX_bubble=0, branch_resolve=0 (with ID_valid=0).
  - rst asserted mid-STALL aborts the stall at that edge.
- Timing: no added latency on the non-hazard path; all control outputs are combinational from state plus inputs.

Decomposition:
- Shared package holds:
  - opcode constants JUMP, JAL, JR, BEQ, BNE, BLT, BGE (shared with the branch resolution unit);
  - fwd_sel encodings FWD_RF=00, FWD_MEM=01, FWD_WB=10;
  - FSM state encoding.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
- BEQ r1,r2 in ID; EX: regwrite, rd=1 -> one cycle with pc_write=0, IFID_write=0, IDEX_bubble=1. Next cycle (producer in MEM): fwd_sel_a=01, branch_resolve=1, stall_count=1.
- BNE rs=r3; EX: memread, rd=3 -> state RUN->STALL->RUN, exactly 2 stall cycles. Then fwd_sel_a=10 with the load in WB, stall_count=2.
- JR r31; MEM: memread, rd=31 -> 1 stall cycle, then fwd_sel_a=10, fwd_sel_b=00 (rt ignored). JUMP with any EX hazard -> 0 stalls.
- BLT r0,r4; EX: memread, rd=0; MEM: regwrite, rd=4 -> no stall, fwd_sel_a=00, fwd_sel_b=01.
- rst pulsed on the first STALL cycle after an EX-load hazard -> next cycle state RUN, pc_write=1, all counters 0. clr_counters concurrent with a taken BEQ resolve -> counters 0.
- CNT_W=4, 20 resolved taken BGE, no hazards -> branch_count=15 and taken_count=15 (saturated), stall_count=0.

Source files
------------

// File: rtl/branch_hazard_controller_pkg.sv
// Shared definitions for the ID-stage branch hazard logic: control opcodes,
// forwarding-select encodings, FSM state codes and an opcode decoder.
package branch_hazard_controller_pkg;

  // Control-transfer opcodes, also used by the branch resolution unit
  localparam logic [5:0] JUMP = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000110;
  localparam logic [5:0] JR   = 6'b000111;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000001;
  localparam logic [5:0] BLT  = 6'b000011;
  localparam logic [5:0] BGE  = 6'b000101;

  // Operand source selects for the ID compare operands
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Hazard FSM state codes
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic is_ctrl;   // any jump/branch handled by this block
    logic is_cond;   // conditional branch (counted)
    logic reads_rs;
    logic reads_rt;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] opcode);
    op_info_t info;
    info = '0;
    case (opcode)
      JUMP, JAL: info.is_ctrl = 1'b1;
      JR: begin
        info.is_ctrl  = 1'b1;
        info.reads_rs = 1'b1;
      end
      BEQ, BNE, BLT, BGE: info = '{is_ctrl: 1'b1, is_cond: 1'b1, reads_rs: 1'b1, reads_rt: 1'b1};
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/branch_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up until all ones, then hold
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_hazard_controller.sv
// ID-stage branch/jump hazard controller: detects operand hazards against
// EX/MEM writers, stalls the front end for the required cycles, selects
// forwarded compare operands, qualifies the redirect and counts events.
module branch_hazard_controller
  import branch_hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ID_instruction,
  input  logic             ID_valid,
  input  logic             EX_regwrite,
  input  logic             EX_memread,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             MEM_regwrite,
  input  logic             MEM_memread,
  input  logic [REG_W-1:0] MEM_rd,
  input  logic             WB_regwrite,
  input  logic [REG_W-1:0] WB_rd,
  input  logic             branch_taken,
  input  logic             clr_counters,
  output logic             pc_write,
  output logic             IFID_write,
  output logic             IDEX_bubble,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             branch_resolve,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  logic [0:0]       state;
  logic [1:0]       rem;
  op_info_t         info;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             use_a;
  logic             use_b;
  logic [1:0]       need_a;
  logic [1:0]       need_b;
  logic [1:0]       need;
  logic             stall;
  logic             cond_resolve;
  logic             unused_bits;

  assign unused_bits = ^ID_instruction[15:0];

  // Stall cycles still owed for one operand given the in-flight writers
  function automatic logic [1:0] need_for(input logic used, input logic [REG_W-1:0] r);
    if (!used)                                   return 2'd0;
    if (EX_memread && (EX_rd == r))              return 2'd2;
    if (EX_regwrite && (EX_rd == r))             return 2'd1;
    if (MEM_memread && (MEM_rd == r))            return 2'd1;
    return 2'd0;
  endfunction

  // Source of one compare operand; MEM ALU result beats WB data
  function automatic fwd_sel_t fwd_for(input logic used, input logic [REG_W-1:0] r);
    if (used && MEM_regwrite && !MEM_memread && (MEM_rd == r)) return FWD_MEM;
    if (used && WB_regwrite && (WB_rd == r))                   return FWD_WB;
    return FWD_RF;
  endfunction

  // Decode, hazard depth and pipeline control, all same-cycle
  always_comb begin
    info   = decode_op(ID_instruction[31:26]);
    rs     = REG_W'(ID_instruction[25:21]);
    rt     = REG_W'(ID_instruction[20:16]);
    use_a  = info.reads_rs && (rs != '0);
    use_b  = info.reads_rt && (rt != '0);
    need_a = need_for(use_a, rs);
    need_b = need_for(use_b, rt);
    need   = (need_a > need_b) ? need_a : need_b;
    stall  = (state == ST_STALL) || (ID_valid && (need != 2'd0));

    pc_write       = !stall;
    IFID_write     = !stall;
    IDEX_bubble    = stall;
    branch_resolve = !stall && ID_valid && info.is_ctrl;
    cond_resolve   = branch_resolve && info.is_cond;
    fwd_sel_a      = fwd_for(use_a, rs);
    fwd_sel_b      = fwd_for(use_b, rt);
  end

  // Only a 2-cycle hazard needs the STALL state; a 1-cycle hazard stays in
  // RUN and is re-evaluated once the producer has advanced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      rem   <= '0;
    end else if (state == ST_STALL) begin
      rem <= rem - 2'd1;
      if (rem == 2'd1) state <= ST_RUN;
    end else if (stall) begin
      rem   <= need - 2'd1;
      state <= (need == 2'd2) ? ST_STALL : ST_RUN;
    end else begin
      rem <= '0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk(clk), .rst(rst), .inc(cond_resolve), .clr(clr_counters), .count(branch_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk(clk), .rst(rst), .inc(cond_resolve && branch_taken), .clr(clr_counters), .count(taken_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall), .clr(clr_counters), .count(stall_count)
  );

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Self-checking bench for branch_hazard_controller: directed scenarios plus a
// randomized run checked against a behavioural model of the hazard rules.
module tb_branch_hazard_controller;

  localparam int unsigned CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  localparam logic [5:0] O_JUMP = 6'b000010;
  localparam logic [5:0] O_JR   = 6'b000111;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_BNE  = 6'b000001;
  localparam logic [5:0] O_BLT  = 6'b000011;
  localparam logic [5:0] O_BGE  = 6'b000101;

  logic          clk;
  logic          rst;
  logic [31:0]   ID_instruction;
  logic          ID_valid;
  logic          EX_regwrite, EX_memread;
  logic [4:0]    EX_rd;
  logic          MEM_regwrite, MEM_memread;
  logic [4:0]    MEM_rd;
  logic          WB_regwrite;
  logic [4:0]    WB_rd;
  logic          branch_taken, clr_counters;
  logic          pc_write, IFID_write, IDEX_bubble, branch_resolve;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic [CW-1:0] branch_count, taken_count, stall_count;

  int vectors = 0;
  int miscompares = 0;

  branch_hazard_controller #(.CNT_W(CW), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .ID_instruction(ID_instruction), .ID_valid(ID_valid),
    .EX_regwrite(EX_regwrite), .EX_memread(EX_memread), .EX_rd(EX_rd),
    .MEM_regwrite(MEM_regwrite), .MEM_memread(MEM_memread), .MEM_rd(MEM_rd),
    .WB_regwrite(WB_regwrite), .WB_rd(WB_rd), .branch_taken(branch_taken),
    .clr_counters(clr_counters), .pc_write(pc_write), .IFID_write(IFID_write),
    .IDEX_bubble(IDEX_bubble), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .branch_resolve(branch_resolve), .branch_count(branch_count),
    .taken_count(taken_count), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b);
    return {op, a, b, 16'h0000};
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic bit m_reads(input logic [5:0] op, input bit is_rt);
    if (op == O_JR) return !is_rt;
    return (op == O_BEQ) || (op == O_BNE) || (op == O_BLT) || (op == O_BGE);
  endfunction

  function automatic bit m_cond(input logic [5:0] op);
    return (op == O_BEQ) || (op == O_BNE) || (op == O_BLT) || (op == O_BGE);
  endfunction

  function automatic bit m_ctrl(input logic [5:0] op);
    return m_cond(op) || (op == O_JR) || (op == O_JUMP) || (op == 6'b000110);
  endfunction

  function automatic int m_need(input logic [5:0] op, input logic [4:0] r, input bit is_rt);
    if (!m_reads(op, is_rt) || r == 0) return 0;
    if (EX_memread && EX_rd == r) return 2;
    if (EX_regwrite && EX_rd == r) return 1;
    if (MEM_memread && MEM_rd == r) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [5:0] op, input logic [4:0] r, input bit is_rt);
    if (!m_reads(op, is_rt) || r == 0) return 2'b00;
    if (MEM_regwrite && !MEM_memread && MEM_rd == r) return 2'b01;
    if (WB_regwrite && WB_rd == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v, input bit inc);
    return (inc && v < MAXC) ? v + 1 : v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ID_valid = 0; ID_instruction = '0;
    EX_regwrite = 0; EX_memread = 0; EX_rd = '0;
    MEM_regwrite = 0; MEM_memread = 0; MEM_rd = '0;
    WB_regwrite = 0; WB_rd = '0;
    branch_taken = 0; clr_counters = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1;
    next_cycle();
    rst = 0;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1100) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 1100", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    vectors++;
    if ({branch_count, taken_count, stall_count} !== '0) begin
      miscompares++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", branch_count, taken_count, stall_count);
    end
    next_cycle();
  endtask

  task automatic test_beq_ex_alu();
    do_reset();
    ID_instruction = mk(O_BEQ, 5'd1, 5'd2); ID_valid = 1; EX_regwrite = 1; EX_rd = 5'd1;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b0010) begin
      miscompares++; $display("FAIL beq_alu_stall: got %b want 0010", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    next_cycle();
    EX_regwrite = 0; EX_rd = '0; MEM_regwrite = 1; MEM_rd = 5'd1; branch_taken = 1;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1101) begin
      miscompares++; $display("FAIL beq_alu_resolve: got %b want 1101", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    vectors++;
    if ({fwd_sel_a, fwd_sel_b} !== 4'b0100) begin
      miscompares++; $display("FAIL beq_alu_fwd: got %b/%b want 01/00", fwd_sel_a, fwd_sel_b);
    end
    vectors++;
    if (stall_count !== CW'(1)) begin
      miscompares++; $display("FAIL beq_alu_stall_count: got %0d want 1", stall_count);
    end
    next_cycle();
    idle();
    settle();
    vectors++;
    if ({branch_count, taken_count} !== {CW'(1), CW'(1)}) begin
      miscompares++; $display("FAIL beq_alu_branch_counts: got %0d/%0d want 1/1", branch_count, taken_count);
    end
  endtask

  task automatic test_bne_load();
    do_reset();
    ID_instruction = mk(O_BNE, 5'd3, 5'd0); ID_valid = 1; EX_memread = 1; EX_regwrite = 1; EX_rd = 5'd3;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b0010) begin
      miscompares++; $display("FAIL bne_load_stall1: got %b want 0010", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    next_cycle();
    EX_memread = 0; EX_regwrite = 0; EX_rd = '0; MEM_memread = 1; MEM_regwrite = 1; MEM_rd = 5'd3;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b0010) begin
      miscompares++; $display("FAIL bne_load_stall2: got %b want 0010", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    next_cycle();
    MEM_memread = 0; MEM_regwrite = 0; MEM_rd = '0; WB_regwrite = 1; WB_rd = 5'd3;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1101) begin
      miscompares++; $display("FAIL bne_load_resolve: got %b want 1101", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    vectors++;
    if (fwd_sel_a !== 2'b10) begin
      miscompares++; $display("FAIL bne_load_fwd_a: got %b want 10", fwd_sel_a);
    end
    vectors++;
    if (stall_count !== CW'(2)) begin
      miscompares++; $display("FAIL bne_load_stall_count: got %0d want 2", stall_count);
    end
  endtask

  task automatic test_jr_jump();
    do_reset();
    ID_instruction = mk(O_JR, 5'd31, 5'd5); ID_valid = 1; MEM_memread = 1; MEM_regwrite = 1; MEM_rd = 5'd31;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b0010) begin
      miscompares++; $display("FAIL jr_stall: got %b want 0010", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    next_cycle();
    MEM_memread = 0; MEM_rd = 5'd5; WB_regwrite = 1; WB_rd = 5'd31;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1101) begin
      miscompares++; $display("FAIL jr_resolve: got %b want 1101", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    vectors++;
    if ({fwd_sel_a, fwd_sel_b} !== 4'b1000) begin
      miscompares++; $display("FAIL jr_fwd: got %b/%b want 10/00", fwd_sel_a, fwd_sel_b);
    end
    next_cycle();
    idle();
    ID_instruction = mk(O_JUMP, 5'd7, 5'd8); ID_valid = 1; EX_memread = 1; EX_regwrite = 1; EX_rd = 5'd7;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1101) begin
      miscompares++; $display("FAIL jump_no_stall: got %b want 1101", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    next_cycle();
    idle();
    settle();
    vectors++;
    if ({stall_count, branch_count} !== {CW'(1), CW'(0)}) begin
      miscompares++; $display("FAIL jr_jump_counts: got stall %0d branch %0d want 1/0", stall_count, branch_count);
    end
  endtask

  task automatic test_blt_r0();
    do_reset();
    ID_instruction = mk(O_BLT, 5'd0, 5'd4); ID_valid = 1;
    EX_memread = 1; EX_regwrite = 1; EX_rd = 5'd0; MEM_regwrite = 1; MEM_rd = 5'd4;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1101) begin
      miscompares++; $display("FAIL blt_r0_ctl: got %b want 1101", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    vectors++;
    if ({fwd_sel_a, fwd_sel_b} !== 4'b0001) begin
      miscompares++; $display("FAIL blt_r0_fwd: got %b/%b want 00/01", fwd_sel_a, fwd_sel_b);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ID_instruction = mk(O_BEQ, 5'd1, 5'd2); ID_valid = 1; EX_memread = 1; EX_regwrite = 1; EX_rd = 5'd1;
    next_cycle();
    EX_memread = 0; EX_regwrite = 0; EX_rd = '0; rst = 1;
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b0010) begin
      miscompares++; $display("FAIL mid_stall_before_rst: got %b want 0010", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    next_cycle();
    rst = 0; idle();
    settle();
    vectors++;
    if ({pc_write, IFID_write, IDEX_bubble, branch_resolve} !== 4'b1100) begin
      miscompares++; $display("FAIL mid_stall_after_rst: got %b want 1100", {pc_write, IFID_write, IDEX_bubble, branch_resolve});
    end
    vectors++;
    if ({branch_count, taken_count, stall_count} !== '0) begin
      miscompares++; $display("FAIL mid_stall_counters: got %0d/%0d/%0d want 0/0/0", branch_count, taken_count, stall_count);
    end
  endtask

  task automatic test_clr_concurrent();
    do_reset();
    ID_instruction = mk(O_BEQ, 5'd1, 5'd2); ID_valid = 1; branch_taken = 1;
    next_cycle();
    clr_counters = 1;
    settle();
    vectors++;
    if ({branch_count, taken_count, branch_resolve} !== {CW'(1), CW'(1), 1'b1}) begin
      miscompares++; $display("FAIL clr_pre: got %0d/%0d res %b want 1/1 res 1", branch_count, taken_count, branch_resolve);
    end
    next_cycle();
    idle();
    settle();
    vectors++;
    if ({branch_count, taken_count, stall_count} !== '0) begin
      miscompares++; $display("FAIL clr_wins: got %0d/%0d/%0d want 0/0/0", branch_count, taken_count, stall_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ID_instruction = mk(O_BGE, 5'd5, 5'd6); ID_valid = 1; branch_taken = 1;
    for (int unsigned i = 0; i < 20; i++) next_cycle();
    idle();
    settle();
    vectors++;
    if ({branch_count, taken_count, stall_count} !== {CW'(15), CW'(15), CW'(0)}) begin
      miscompares++; $display("FAIL saturation: got %0d/%0d/%0d want 15/15/0", branch_count, taken_count, stall_count);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [4:0] ra, rb;
    int         left, bc, tc, sc, n;
    bit         e_stall, e_res;
    logic [7:0] exp_v, got_v;
    ops = '{6'b000010, 6'b000110, 6'b000111, 6'b000100, 6'b000001,
            6'b000011, 6'b000101, 6'b000000, 6'b100011, 6'b101011};
    do_reset();
    left = 0; bc = 0; tc = 0; sc = 0;
    for (int unsigned i = 0; i < 500; i++) begin
      op = ops[$urandom_range(0, 9)];
      ra = 5'($urandom_range(0, 3));
      rb = 5'($urandom_range(0, 3));
      ID_instruction = {op, ra, rb, 16'($urandom)};
      ID_valid     = ($urandom_range(0, 3) != 0);
      EX_regwrite  = 1'($urandom); EX_memread  = 1'($urandom); EX_rd  = 5'($urandom_range(0, 3));
      MEM_regwrite = 1'($urandom); MEM_memread = 1'($urandom); MEM_rd = 5'($urandom_range(0, 3));
      WB_regwrite  = 1'($urandom); WB_rd = 5'($urandom_range(0, 3));
      branch_taken = 1'($urandom);
      clr_counters = ($urandom_range(0, 11) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      settle();
      n = m_need(op, ra, 0);
      if (m_need(op, rb, 1) > n) n = m_need(op, rb, 1);
      e_stall = (left > 0) || (ID_valid && n > 0);
      e_res   = !e_stall && ID_valid && m_ctrl(op);
      exp_v = {!e_stall, !e_stall, e_stall, e_res, m_fwd(op, ra, 0), m_fwd(op, rb, 1)};
      got_v = {pc_write, IFID_write, IDEX_bubble, branch_resolve, fwd_sel_a, fwd_sel_b};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL random_ctl[%0d]: got %b want %b", i, got_v, exp_v);
      end
      vectors++;
      if ({branch_count, taken_count, stall_count} !== {CW'(bc), CW'(tc), CW'(sc)}) begin
        miscompares++; $display("FAIL random_counters[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                                i, branch_count, taken_count, stall_count, bc, tc, sc);
      end
      if (rst) begin
        left = 0; bc = 0; tc = 0; sc = 0;
      end else begin
        if (left > 0) left--;
        else if (e_stall) left = n - 1;
        if (clr_counters) begin
          bc = 0; tc = 0; sc = 0;
        end else begin
          bc = sat_inc(bc, e_res && m_cond(op));
          tc = sat_inc(tc, e_res && m_cond(op) && branch_taken);
          sc = sat_inc(sc, e_stall);
        end
      end
      next_cycle();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_beq_ex_alu();
    test_bne_load();
    test_jr_jump();
    test_blt_r0();
    test_reset_mid_stall();
    test_clr_concurrent();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
